// File: rtl/uart_word_tx.sv
// Word-level UART transmitter: {ctrl,data} words are queued in a small FIFO and sent
// as NBYTES characters, least significant byte first, with optional parity and 1/2 stop bits.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 32,
    parameter int CTRL_W       = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    localparam int LW          = $clog2(FIFO_DEPTH + 1),
    localparam int CTRL_PW     = (CTRL_W > 0) ? CTRL_W : 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [CTRL_PW-1:0]  in_ctrl,
    output logic                TX,
    output logic                busy,
    output logic                word_done,
    output logic [LW-1:0]       fifo_level
);

    localparam int WORD_W    = DATA_W + CTRL_W;
    localparam int NBYTES    = (WORD_W + 7) / 8;
    localparam int SW        = NBYTES * 8;
    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int CNT_W     = $clog2(STOP_CLKS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              rdy_q;
    logic              push, pop;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_cnt_q;
    logic [2:0]        bit_nxt;
    logic [BW-1:0]     byte_cnt_q;
    logic [SW-1:0]     shreg_q;
    logic [7:0]        cur_byte;
    logic              par_bit;
    logic              tx_q, busy_q, done_q;

    generate
        if (CTRL_W > 0) begin : g_ctrl
            assign in_word = {in_ctrl, in_data};
        end else begin : g_noctrl
            assign in_word = in_data;
        end
    endgenerate

    // A word is popped only from IDLE, so a full FIFO never bypasses into the shifter.
    assign push = in_valid & rdy_q;
    assign pop  = (state_q == S_IDLE) && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= in_word;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdy_q    <= (level_d < LW'(FIFO_DEPTH));
        end
    end

    assign cur_byte = shreg_q[7:0];
    assign bit_nxt  = bit_cnt_q + 3'd1;
    assign par_bit  = (PARITY == 1) ? ^cur_byte : ~^cur_byte;

    // The baud counter restarts on every state or bit change; STOP counts all stop bits at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (level_q != '0) begin
                        shreg_q    <= SW'(mem_q[rd_ptr_q]);
                        byte_cnt_q <= '0;
                        cnt_q      <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        tx_q      <= cur_byte[0];
                        state_q   <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            if (PARITY != 0) begin
                                tx_q    <= par_bit;
                                state_q <= S_PAR;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_cnt_q <= bit_nxt;
                            tx_q      <= cur_byte[bit_nxt];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PAR: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_W'(STOP_CLKS - 1)) begin
                        cnt_q <= '0;
                        if (byte_cnt_q != BW'(NBYTES - 1)) begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            shreg_q    <= shreg_q >> 8;
                            tx_q       <= 1'b0;
                            state_q    <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = rdy_q;
    assign TX         = tx_q;
    assign busy       = busy_q;
    assign word_done  = done_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: five instances cover no/even/odd parity, two stop bits
// and single-cycle bits; every expected value is written down by hand.
module tb_uart_word_tx;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        vld [5];
  logic [31:0] dat;
  logic [1:0]  ctl;
  logic        rdy_w [5];
  logic        tx_w [5];
  logic        busy_w [5];
  logic        wd_w [5];
  logic [2:0]  lvl_w [5];

  int n_chk = 0;
  int n_fail = 0;

  logic       cap_tx [256];
  logic       cap_wd [256];
  logic       cap_busy [256];
  logic [7:0] exp_b [5];
  logic [39:0] exp_q [$];
  logic [39:0] rx_q [$];

  // u0: 4 clk/bit, no parity, 1 stop; u1 even; u2 odd; u3 two stop bits; u4 1 clk/bit
  uart_word_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (.CLK(CLK), .RST_N(RST_N),
    .in_valid(vld[0]), .in_ready(rdy_w[0]), .in_data(dat), .in_ctrl(ctl), .TX(tx_w[0]),
    .busy(busy_w[0]), .word_done(wd_w[0]), .fifo_level(lvl_w[0]));
  uart_word_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (.CLK(CLK), .RST_N(RST_N),
    .in_valid(vld[1]), .in_ready(rdy_w[1]), .in_data(dat), .in_ctrl(ctl), .TX(tx_w[1]),
    .busy(busy_w[1]), .word_done(wd_w[1]), .fifo_level(lvl_w[1]));
  uart_word_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u2 (.CLK(CLK), .RST_N(RST_N),
    .in_valid(vld[2]), .in_ready(rdy_w[2]), .in_data(dat), .in_ctrl(ctl), .TX(tx_w[2]),
    .busy(busy_w[2]), .word_done(wd_w[2]), .fifo_level(lvl_w[2]));
  uart_word_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u3 (.CLK(CLK), .RST_N(RST_N),
    .in_valid(vld[3]), .in_ready(rdy_w[3]), .in_data(dat), .in_ctrl(ctl), .TX(tx_w[3]),
    .busy(busy_w[3]), .word_done(wd_w[3]), .fifo_level(lvl_w[3]));
  uart_word_tx #(.CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1)) u4 (.CLK(CLK), .RST_N(RST_N),
    .in_valid(vld[4]), .in_ready(rdy_w[4]), .in_data(dat), .in_ctrl(ctl), .TX(tx_w[4]),
    .busy(busy_w[4]), .word_done(wd_w[4]), .fifo_level(lvl_w[4]));

  always #5 CLK = ~CLK;

  // Frame decoder for u0 (4 clk/bit, 40-cycle chars, 5 chars per word), sampled on the falling clock.
  logic        mon_act;
  int          mon_cnt;
  logic [39:0] mon_word;
  always @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mon_act = 1'b0;
      mon_cnt = 0;
    end else if (!mon_act) begin
      if (tx_w[0] == 1'b0) begin
        mon_act  = 1'b1;
        mon_cnt  = 1;
        mon_word = '0;
      end
    end else begin
      if ((mon_cnt % 40) >= 6 && (mon_cnt % 40) <= 34 && ((mon_cnt % 40) - 6) % 4 == 0)
        mon_word[8 * (mon_cnt / 40) + ((mon_cnt % 40) - 6) / 4] = tx_w[0];
      mon_cnt++;
      if (mon_cnt == 200) begin
        rx_q.push_back(mon_word);
        mon_act = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input int idx, input logic [31:0] d, input logic [1:0] c);
    vld[idx] = 1'b1;
    dat = d;
    ctl = c;
    @(posedge CLK); #1;
    vld[idx] = 1'b0;
  endtask

  task automatic capture(input int idx, input int n);
    for (int c = 0; c < n; c++) begin
      cap_tx[c]   = tx_w[idx];
      cap_wd[c]   = wd_w[idx];
      cap_busy[c] = busy_w[idx];
      @(posedge CLK); #1;
    end
  endtask

  function automatic logic [7:0] get_byte(input int base, input int cpb);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = cap_tx[base + cpb * (1 + j) + cpb / 2];
    return b;
  endfunction

  task automatic check_frame(input string nm, input int base, input int cpb, input int char_len,
                             input int word_len);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s byte%0d", nm, k), 64'(get_byte(base + k * char_len, cpb)), 64'(exp_b[k]));
      check($sformatf("%s start%0d", nm, k), 64'(cap_tx[base + k * char_len]), 64'd0);
      check($sformatf("%s stop_end%0d", nm, k), 64'(cap_tx[base + k * char_len + char_len - 1]), 64'd1);
    end
    check({nm, " word_done_early"}, 64'(cap_wd[base + word_len - 1]), 64'd0);
    check({nm, " word_done"}, 64'(cap_wd[base + word_len]), 64'd1);
  endtask

  initial begin
    int n_acc;
    int guard;
    int lows;
    logic rdy_prev;
    logic [4:0] par_even;
    logic [4:0] par_odd;

    for (int i = 0; i < 5; i++) vld[i] = 1'b0;
    dat = '0;
    ctl = '0;
    RST_N = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst tx u%0d", i), 64'(tx_w[i]), 64'd1);
      check($sformatf("rst busy u%0d", i), 64'(busy_w[i]), 64'd0);
      check($sformatf("rst level u%0d", i), 64'(lvl_w[i]), 64'd0);
      check($sformatf("rst ready u%0d", i), 64'(rdy_w[i]), 64'd0);
      check($sformatf("rst done u%0d", i), 64'(wd_w[i]), 64'd0);
    end
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("ready after release", 64'(rdy_w[0]), 64'd1);

    // Test 1: 0xA5A50F01 ctrl 2'b10 -> 01 0F A5 A5 02, 40 cycles per char
    push_one(0, 32'hA5A5_0F01, 2'b10);
    check("t1 tx before pop", 64'(tx_w[0]), 64'd1);
    check("t1 level after push", 64'(lvl_w[0]), 64'd1);
    @(posedge CLK); #1;
    capture(0, 203);
    exp_b[0] = 8'h01; exp_b[1] = 8'h0F; exp_b[2] = 8'hA5; exp_b[3] = 8'hA5; exp_b[4] = 8'h02;
    check_frame("t1", 0, 4, 40, 200);
    check("t1 busy first", 64'(cap_busy[0]), 64'd1);
    check("t1 busy last", 64'(cap_busy[199]), 64'd1);
    check("t1 busy after", 64'(cap_busy[201]), 64'd0);
    check("t1 done one cycle", 64'(cap_wd[201]), 64'd0);
    check("t1 idle tx", 64'(cap_tx[201]), 64'd1);

    // Test 2: byte 0x01 then zeros with even / odd parity, 44-cycle chars
    exp_b[0] = 8'h01; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00; exp_b[4] = 8'h00;
    par_even = 5'b00001;
    par_odd  = 5'b11110;
    push_one(1, 32'h0000_0001, 2'b00);
    @(posedge CLK); #1;
    capture(1, 222);
    check_frame("t2 even", 0, 4, 44, 220);
    for (int k = 0; k < 5; k++)
      check($sformatf("t2 even parity%0d", k), 64'(cap_tx[k * 44 + 38]), 64'(par_even[k]));
    push_one(2, 32'h0000_0001, 2'b00);
    @(posedge CLK); #1;
    capture(2, 222);
    check_frame("t2 odd", 0, 4, 44, 220);
    for (int k = 0; k < 5; k++)
      check($sformatf("t2 odd parity%0d", k), 64'(cap_tx[k * 44 + 38]), 64'(par_odd[k]));

    // Test 3: two stop bits, data 0 ctrl 2'b11 -> 00 00 00 00 03
    exp_b[0] = 8'h00; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00; exp_b[4] = 8'h03;
    push_one(3, 32'h0000_0000, 2'b11);
    @(posedge CLK); #1;
    capture(3, 222);
    check_frame("t3", 0, 4, 44, 220);
    check("t3 last data bit", 64'(cap_tx[35]), 64'd0);
    check("t3 stop first", 64'(cap_tx[36]), 64'd1);
    check("t3 stop last", 64'(cap_tx[43]), 64'd1);
    check("t3 next start", 64'(cap_tx[44]), 64'd0);

    // Test 4: hold in_valid for 8 edges; producer advances the word only when accepted
    rx_q.delete();
    n_acc = 0;
    rdy_prev = rdy_w[0];
    for (int c = 0; c < 8; c++) begin
      vld[0] = 1'b1;
      dat = 32'h1000_0000 + 32'(n_acc);
      ctl = 2'(n_acc);
      @(posedge CLK); #1;
      if (rdy_prev) begin
        exp_q.push_back({6'b0, ctl, dat});
        n_acc++;
      end
      check($sformatf("t4 ready vs level c%0d", c), 64'(rdy_w[0]), 64'(lvl_w[0] != 3'd4));
      rdy_prev = rdy_w[0];
    end
    vld[0] = 1'b0;
    check("t4 accepted count", 64'(n_acc), 64'd5);
    check("t4 level full", 64'(lvl_w[0]), 64'd4);
    check("t4 ready full", 64'(rdy_w[0]), 64'd0);
    guard = 0;
    while (rx_q.size() < 5 && guard < 1500) begin
      @(posedge CLK);
      guard++;
    end
    #1;
    check("t4 words received", 64'(rx_q.size()), 64'd5);
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check("t4 word order", 64'(rx_q.pop_front()), 64'(exp_q.pop_front()));
    repeat (20) @(posedge CLK);
    #1;
    check("t4 no extra words", 64'(rx_q.size()), 64'd0);
    check("t4 drained level", 64'(lvl_w[0]), 64'd0);
    check("t4 drained busy", 64'(busy_w[0]), 64'd0);

    // Test 5: reset during byte 2 with two words queued
    exp_q.delete();
    vld[0] = 1'b1; dat = 32'h1111_1111; ctl = 2'b01;
    @(posedge CLK); #1;
    dat = 32'h2222_2222;
    @(posedge CLK); #1;
    dat = 32'h3333_3333;
    @(posedge CLK); #1;
    vld[0] = 1'b0;
    check("t5 queued", 64'(lvl_w[0]), 64'd2);
    repeat (85) @(posedge CLK);
    #1;
    check("t5 busy before reset", 64'(busy_w[0]), 64'd1);
    RST_N = 1'b0;
    #1;
    check("t5 tx in reset", 64'(tx_w[0]), 64'd1);
    check("t5 busy in reset", 64'(busy_w[0]), 64'd0);
    check("t5 level in reset", 64'(lvl_w[0]), 64'd0);
    check("t5 ready in reset", 64'(rdy_w[0]), 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    #1;
    check("t5 ready before edge", 64'(rdy_w[0]), 64'd0);
    @(posedge CLK); #1;
    check("t5 ready after edge", 64'(rdy_w[0]), 64'd1);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) lows++;
      @(posedge CLK); #1;
    end
    check("t5 line quiet after reset", 64'(lows), 64'd0);
    check("t5 no word after reset", 64'(rx_q.size()), 64'd0);
    push_one(0, 32'hCAFE_0055, 2'b01);
    @(posedge CLK); #1;
    check("t5 new word starts", 64'(tx_w[0]), 64'd0);
    guard = 0;
    while (rx_q.size() < 1 && guard < 400) begin
      @(posedge CLK);
      guard++;
    end
    #1;
    check("t5 new word received", 64'(rx_q.size()), 64'd1);
    if (rx_q.size() > 0)
      check("t5 new word value", 64'(rx_q.pop_front()), 64'({6'b0, 2'b01, 32'hCAFE_0055}));

    // Test 6: 1 clk/bit, two words back to back
    vld[4] = 1'b1; dat = 32'h5A5A_C3E7; ctl = 2'b01;
    @(posedge CLK); #1;
    dat = 32'h0123_4567; ctl = 2'b10;
    @(posedge CLK); #1;
    vld[4] = 1'b0;
    capture(4, 103);
    exp_b[0] = 8'hE7; exp_b[1] = 8'hC3; exp_b[2] = 8'h5A; exp_b[3] = 8'h5A; exp_b[4] = 8'h01;
    check_frame("t6 a", 0, 1, 10, 50);
    exp_b[0] = 8'h67; exp_b[1] = 8'h45; exp_b[2] = 8'h23; exp_b[3] = 8'h01; exp_b[4] = 8'h02;
    check_frame("t6 b", 51, 1, 10, 50);
    check("t6 last data bit", 64'(cap_tx[48]), 64'd0);
    check("t6 stop bit", 64'(cap_tx[49]), 64'd1);
    check("t6 idle gap", 64'(cap_tx[50]), 64'd1);
    check("t6 second start", 64'(cap_tx[51]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
